// File: rtl/ahb_code_pkg.sv
// Shared encodings for the code-region AHB-Lite response path:
// transfer types, response codes and default-slave FSM states.
package ahb_code_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] DS_IDLE = 2'b00;
    localparam logic [1:0] DS_ERR1 = 2'b01;
    localparam logic [1:0] DS_ERR2 = 2'b10;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped code-region accesses: zero-wait OKAY for
// IDLE/BUSY, two-cycle ERROR for NONSEQ/SEQ.
module ahb_default_slave
    import ahb_code_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       accept;

    assign accept = HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (accept) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = accept ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign HREADYOUT = (state_q != DS_ERR1);
    assign HRESP     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_slave_mux_code.sv
// Code-region AHB-Lite data-phase response mux: registers address-phase
// selects and routes the owning slave's HRDATA/HREADYOUT/HRESP to the master.
module ahb_slave_mux_code
    import ahb_code_pkg::*;
#(
    parameter int NPORT = 1,
    parameter int DW    = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [NPORT-1:0]    HSEL,
    input  logic                HSEL_DefSlave,
    input  logic [1:0]          HTRANS,
    input  logic [NPORT*DW-1:0] HRDATA_S,
    input  logic [NPORT-1:0]    HREADYOUT_S,
    input  logic [NPORT-1:0]    HRESP_S,
    output logic [DW-1:0]       HRDATA,
    output logic                HREADY,
    output logic                HRESP
);

    logic [NPORT-1:0] sel_q;
    logic [NPORT-1:0] sel_d;
    logic [NPORT-1:0] hsel_prio;
    logic             def_q;
    logic             def_d;
    logic             def_sel;
    logic             ds_hreadyout;
    logic             ds_hresp;

    // Lowest set HSEL bit wins; any real slave select masks the default slave.
    assign hsel_prio = HSEL & (~HSEL + NPORT'(1));
    assign def_sel   = HSEL_DefSlave && !(|HSEL);

    assign sel_d = HREADY ? hsel_prio : sel_q;
    assign def_d = HREADY ? def_sel   : def_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            def_q <= def_d;
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (def_sel),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp)
    );

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (|sel_q) begin
            for (int i = NPORT - 1; i >= 0; i--) begin
                if (sel_q[i]) begin
                    HRDATA = HRDATA_S[i*DW +: DW];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end else if (def_q) begin
            HREADY = ds_hreadyout;
            HRESP  = ds_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux_code.sv
// Self-checking bench for ahb_slave_mux_code: directed scenarios plus
// randomized traffic compared against a transaction-level ownership model.
module tb_ahb_slave_mux_code;

    localparam int NPORT = 2;
    localparam int DW    = 32;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic                hclk = 1'b0;
    logic                hresetn = 1'b0;
    logic [NPORT-1:0]    hsel = '0;
    logic                hsel_def = 1'b0;
    logic [1:0]          htrans = T_IDLE;
    logic [NPORT*DW-1:0] hrdata_s = '0;
    logic [NPORT-1:0]    hreadyout_s = '1;
    logic [NPORT-1:0]    hresp_s = '0;
    logic [DW-1:0]       hrdata;
    logic                hready;
    logic                hresp;

    int errors = 0;
    int checks = 0;

    // Model: owner of the current data phase (-1 none, 0..NPORT-1 slave,
    // NPORT default slave) and remaining ERROR cycles of the default slave.
    int owner    = -1;
    int err_left = 0;

    ahb_slave_mux_code #(.NPORT(NPORT), .DW(DW)) dut (
        .HCLK          (hclk),
        .HRESETn       (hresetn),
        .HSEL          (hsel),
        .HSEL_DefSlave (hsel_def),
        .HTRANS        (htrans),
        .HRDATA_S      (hrdata_s),
        .HREADYOUT_S   (hreadyout_s),
        .HRESP_S       (hresp_s),
        .HRDATA        (hrdata),
        .HREADY        (hready),
        .HRESP         (hresp)
    );

    initial forever #5 hclk = ~hclk;

    function automatic int resolve(logic [NPORT-1:0] s, logic d);
        for (int i = 0; i < NPORT; i++) begin
            if (s[i]) return i;
        end
        return d ? NPORT : -1;
    endfunction

    task automatic model_reset();
        owner    = -1;
        err_left = 0;
    endtask

    task automatic model_expect(output logic [DW-1:0] r, output logic y, output logic e);
        r = '0;
        y = 1'b1;
        e = 1'b0;
        if (owner >= 0 && owner < NPORT) begin
            r = hrdata_s[owner*DW +: DW];
            y = hreadyout_s[owner];
            e = hresp_s[owner];
        end else if (owner == NPORT && err_left > 0) begin
            y = (err_left == 1);
            e = 1'b1;
        end
    endtask

    task automatic tick();
        logic [DW-1:0] r;
        logic          y;
        logic          e;
        model_expect(r, y, e);
        @(posedge hclk);
        if (!hresetn) begin
            model_reset();
        end else if (y) begin
            owner    = resolve(hsel, hsel_def);
            err_left = (owner == NPORT && htrans[1]) ? 2 : 0;
        end else if (err_left == 2) begin
            err_left = 1;
        end
        #1;
    endtask

    task automatic drive(logic [NPORT-1:0] s, logic d, logic [1:0] t);
        hsel     = s;
        hsel_def = d;
        htrans   = t;
    endtask

    task automatic test_reset();
        model_reset();
        hresetn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            hsel        = NPORT'($urandom);
            hsel_def    = 1'($urandom);
            htrans      = 2'($urandom);
            hrdata_s    = {$urandom, $urandom};
            hreadyout_s = NPORT'($urandom);
            hresp_s     = NPORT'($urandom);
            @(negedge hclk);
            checks++;
            if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                         k, hrdata, hready, hresp);
            end
        end
        drive('0, 1'b0, T_IDLE);
        hresetn = 1'b1;
        #1;
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        tick();
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_cycle: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
    endtask

    task automatic test_rom_read();
        hreadyout_s = '1;
        hresp_s     = '0;
        hrdata_s    = {$urandom, 32'h1234_5678};
        drive(2'b01, 1'b0, T_NONSEQ);
        tick();
        drive(2'b00, 1'b0, T_IDLE);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h1234_5678, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rom_read: got data=%h ready=%b resp=%b, want data=12345678 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        tick();
    endtask

    task automatic test_rom_wait();
        hreadyout_s = '1;
        hresp_s     = '0;
        hrdata_s    = {$urandom, 32'h1234_5678};
        drive(2'b01, 1'b0, T_NONSEQ);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, T_NONSEQ);
            hreadyout_s[0] = (k == 3);
            @(negedge hclk);
            checks++;
            if ({hrdata, hready, hresp} !== {32'h1234_5678, (k == 3), 1'b0}) begin
                errors++;
                $display("FAIL rom_wait[%0d]: got data=%h ready=%b resp=%b, want data=12345678 ready=%0d resp=0",
                         k, hrdata, hready, hresp, (k == 3));
            end
            tick();
        end
        hreadyout_s = '1;
        drive(2'b00, 1'b0, T_IDLE);
        tick();
    endtask

    task automatic test_unmapped();
        logic [1:0] exp_tbl [3] = '{2'b01, 2'b11, 2'b10};
        drive(2'b00, 1'b1, T_NONSEQ);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 1'b1, T_IDLE);
            @(negedge hclk);
            checks++;
            if ({hrdata, hready, hresp} !== {32'h0, exp_tbl[k]}) begin
                errors++;
                $display("FAIL unmapped[%0d]: got data=%h ready=%b resp=%b, want data=0 ready/resp=%b",
                         k, hrdata, hready, hresp, exp_tbl[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_tbl [5] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
        drive(2'b00, 1'b1, T_NONSEQ);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(2'b00, 1'b1, (k <= 1) ? T_NONSEQ : T_IDLE);
            @(negedge hclk);
            checks++;
            if ({hrdata, hready, hresp} !== {32'h0, exp_tbl[k]}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got data=%h ready=%b resp=%b, want data=0 ready/resp=%b",
                         k, hrdata, hready, hresp, exp_tbl[k]);
            end
            tick();
        end
    endtask

    task automatic test_idle_default();
        drive(2'b00, 1'b1, T_IDLE);
        tick();
        drive(2'b00, 1'b1, T_BUSY);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle_default: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        tick();
        drive(2'b00, 1'b0, T_IDLE);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL busy_default: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        tick();
    endtask

    task automatic test_handover();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = $urandom;
        b = $urandom;
        hrdata_s    = {b, a};
        hreadyout_s = '1;
        hresp_s     = 2'b10;
        drive(2'b01, 1'b0, T_NONSEQ);
        tick();
        drive(2'b00, 1'b1, T_NONSEQ);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {a, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL handover_slave0: got data=%h ready=%b resp=%b, want data=%h ready=1 resp=0",
                     hrdata, hready, hresp, a);
        end
        tick();
        drive(2'b10, 1'b0, T_NONSEQ);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL handover_err1: got data=%h ready=%b resp=%b, want data=0 ready=0 resp=1",
                     hrdata, hready, hresp);
        end
        tick();
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL handover_err2: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=1",
                     hrdata, hready, hresp);
        end
        tick();
        drive(2'b00, 1'b0, T_IDLE);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {b, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL handover_slave1: got data=%h ready=%b resp=%b, want data=%h ready=1 resp=1",
                     hrdata, hready, hresp, b);
        end
        tick();
        hresp_s = '0;
    endtask

    task automatic test_priority();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = $urandom;
        b = $urandom;
        hrdata_s    = {b, a};
        hreadyout_s = '1;
        hresp_s     = '0;
        drive(2'b11, 1'b1, T_NONSEQ);
        tick();
        drive(2'b10, 1'b1, T_NONSEQ);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {a, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL priority_low_index: got data=%h ready=%b resp=%b, want data=%h ready=1 resp=0",
                     hrdata, hready, hresp, a);
        end
        tick();
        drive(2'b00, 1'b0, T_IDLE);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {b, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL priority_over_default: got data=%h ready=%b resp=%b, want data=%h ready=1 resp=0",
                     hrdata, hready, hresp, b);
        end
        tick();
    endtask

    task automatic test_reset_mid_error();
        drive(2'b00, 1'b1, T_NONSEQ);
        tick();
        drive(2'b00, 1'b0, T_IDLE);
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_error_err1: got data=%h ready=%b resp=%b, want data=0 ready=0 resp=1",
                     hrdata, hready, hresp);
        end
        hresetn = 1'b0;
        #1;
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        model_reset();
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        @(negedge hclk);
        checks++;
        if ({hrdata, hready, hresp} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: got data=%h ready=%b resp=%b, want data=0 ready=1 resp=0",
                     hrdata, hready, hresp);
        end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] r;
        logic          y;
        logic          e;
        int            pick;
        for (int k = 0; k < 400; k++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0, 1, 2: hsel = 2'b00;
                3, 4:    hsel = 2'b01;
                5, 6:    hsel = 2'b10;
                default: hsel = 2'b11;
            endcase
            hsel_def       = 1'($urandom_range(0, 1));
            htrans         = 2'($urandom_range(0, 3));
            hrdata_s       = {$urandom, $urandom};
            hreadyout_s[0] = ($urandom_range(0, 3) != 0);
            hreadyout_s[1] = ($urandom_range(0, 3) != 0);
            hresp_s        = NPORT'($urandom_range(0, 3));
            @(negedge hclk);
            model_expect(r, y, e);
            checks++;
            if ({hrdata, hready, hresp} !== {r, y, e}) begin
                errors++;
                $display("FAIL random[%0d]: got data=%h ready=%b resp=%b, want data=%h ready=%b resp=%b",
                         k, hrdata, hready, hresp, r, y, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_rom_wait();
        test_unmapped();
        test_back_to_back();
        test_idle_default();
        test_handover();
        test_priority();
        test_reset_mid_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mux_code.md
# ahb_slave_mux_code

Data-phase response multiplexer for the code-region AHB-Lite bus of the Cortex-M3 MCU system. It sits between the code-region address decoder and the bus master. It registers the decoder's slave selects in the address phase. In the following data phase it routes the selected slave's HRDATA, HREADYOUT and HRESP back to the master. It also contains the default slave that answers unmapped accesses with the two-cycle AHB ERROR response.

## Interface
- NPORT, default 1: number of real slave ports (ROM is port 0).
- DW, default 32: data width.

- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- HSEL  input  NPORT  address-phase selects from the decoder, bit i = slave i.
- HSEL_DefSlave  input  1  address-phase select for the internal default slave.
- HTRANS  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HRDATA_S  input  NPORT*DW  packed slave read data, slave i at [i*DW +: DW].
- HREADYOUT_S  input  NPORT  per-slave ready.
- HRESP_S  input  NPORT  per-slave response (0 OKAY, 1 ERROR).
- HRDATA  output  DW  muxed read data to master.
- HREADY  output  1  muxed ready to master and to all slaves' HREADY inputs.
- HRESP  output  1  muxed response to master.

## Operation
- Data-phase select register sel_q[NPORT-1:0] and def_q.
  - Both load from HSEL and HSEL_DefSlave on a rising edge with HREADY=1.
  - Both hold while HREADY=0.
- Select priority: if more than one HSEL bit is set, the lowest index wins.
  - Any HSEL bit beats HSEL_DefSlave.
  - The decoder guarantees one-hot selects; this priority only defines behaviour if that is violated.
- Response mux, combinational from the registered selects:
  - sel_q has a bit set: forward that slave's HRDATA_S, HREADYOUT_S and HRESP_S.
  - else def_q=1: forward the default slave's outputs, with HRDATA = 0.
  - else (no data phase owner): HRDATA=0, HREADY=1, HRESP=0.
- Default slave FSM, states IDLE, ERR1 and ERR2:
  - IDLE: outputs HREADYOUT=1, HRESP=0. Go to ERR1 when HSEL_DefSlave=1, HTRANS[1]=1 and HREADY=1. Otherwise stay in IDLE.
  - ERR1: outputs HREADYOUT=0, HRESP=1. Go to ERR2 unconditionally.
  - ERR2: outputs HREADYOUT=1, HRESP=1. Go to ERR1 if a new default NONSEQ/SEQ is accepted (HREADY is 1 here). Otherwise go to IDLE.
  - IDLE or BUSY transfers to the default slave get a zero-wait OKAY and stay in IDLE.
- Reset: sel_q=0, def_q=0, FSM=IDLE. Outputs are therefore HRDATA=0, HREADY=1, HRESP=0 while reset is asserted and on the first cycle after release.
- Reset mid-transfer: all state clears at once, asynchronously. No partial ERROR sequence survives.

## Timing
- The response path is purely combinational from the registers and slave inputs, with zero added latency. A slave's HREADYOUT reaches HREADY in the same cycle.
- Select latency: an address phase accepted at edge n owns the data phase in the cycle that follows edge n.
- Wait states: as long as the selected slave drives HREADYOUT=0, HREADY is 0 and sel_q and def_q are frozen. The next address phase (HSEL and HTRANS) is not sampled until HREADY=1.
- Default ERROR is exactly 2 data-phase cycles:
  - cycle 1: HREADY=0, HRESP=1;
  - cycle 2: HREADY=1, HRESP=1.
  - Back-to-back unmapped accesses repeat ERR1, ERR2, ERR1, ERR2 with no IDLE cycle between them.
- Simultaneous events: HREADY=1 at the edge that ends one data phase also captures the next address phase. A handover from slave i to the default slave, or the reverse, has no bubble.

## Structure
- Shared package `ahb_code_pkg`:
  - HTRANS encodings;
  - HRESP_OKAY and HRESP_ERROR;
  - default-slave state encodings (2-bit: IDLE=00, ERR1=01, ERR2=10).
- One sub-module, `ahb_default_slave`. It contains the FSM and takes HCLK, HRESETn, HSEL, HTRANS and HREADY as inputs. It outputs HREADYOUT and HRESP.
- The top level holds the select registers, the priority logic and the mux.

## Test plan
- Reset: hold HRESETn=0 with all slave inputs random. Required: HRDATA=0, HREADY=1, HRESP=0 during reset and on the first cycle after release.
- ROM read: HSEL=1, HTRANS=10, HREADYOUT_S=1, HRDATA_S=0x1234_5678. Required: in the next cycle HRDATA=0x1234_5678, HREADY=1, HRESP=0.
- ROM wait states: as in the ROM read, with HREADYOUT_S=0 for 3 data cycles and HSEL changed to 0 during the wait. Required: HREADY=0 for 3 cycles; the ROM data is still forwarded on the 4th cycle.
- Unmapped access: HSEL=0, HSEL_DefSlave=1, HTRANS=10. Required: next cycle HREADY=0, HRESP=1; then HREADY=1, HRESP=1; then, with HTRANS=00, HREADY=1, HRESP=0.
- Back-to-back and IDLE cases:
  - Two consecutive NONSEQ transfers to the default slave. Required: ERR1, ERR2, ERR1, ERR2.
  - An IDLE transfer to the default slave. Required: zero-wait OKAY.
- Reset mid-ERROR: assert HRESETn=0 during ERR1. Required: HREADY=1 and HRESP=0 immediately, without waiting for a clock edge.
